// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, transmitter FSM encoding and a parity helper.
// The future uart_rx_param imports this package too.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Widest supported data word; the parity helper works on this width
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Zero-extended data does not change the XOR, so narrower words can be passed in
    function automatic logic calc_parity(input int mode, input logic [MAX_DATA_BITS-1:0] data);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering words between the producer handshake and the transmitter FSM.
// Pointers wrap naturally because DEPTH is a power of two; the count guards against over/underflow.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO; sends queued words back-to-back with no idle gap.
// o_tx is registered from the current FSM state, so the line trails the state register by one clock.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam bit               HAS_PAR   = (PARITY_MODE != PARITY_NONE);

    tx_state_e             state;
    tx_state_e             state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      idx_next;
    logic [DATA_BITS-1:0]  shift;
    logic [DATA_BITS-1:0]  shift_next;
    logic                  par_bit;
    logic                  par_next;
    logic                  tx_next;
    logic                  busy_next;
    logic                  bit_end;
    logic                  load_word;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_head;

    assign o_ready   = ~fifo_full;
    assign fifo_push = i_valid & o_ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (i_reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (i_data),
        .rd_data (fifo_head),
        .count   (o_fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            bit_idx <= idx_next;
            shift   <= shift_next;
            par_bit <= par_next;
            o_tx    <= tx_next;
            o_busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        idx_next   = bit_idx;
        shift_next = shift;
        par_next   = par_bit;
        load_word  = 1'b0;
        fifo_pop   = 1'b0;
        bit_end    = (bit_cnt == CNT_LAST);

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_word = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_next   = '0;
                        state_next = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_STOP;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        idx_next   = '0;
                        state_next = ST_IDLE;
                        // Chain straight into the next frame so queued words leave with no gap
                        if (!fifo_empty) begin
                            load_word = 1'b1;
                        end
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        if (load_word) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            par_next   = calc_parity(PARITY_MODE, MAX_DATA_BITS'(fifo_head));
            cnt_next   = '0;
            idx_next   = '0;
            state_next = ST_START;
        end

        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift[0];
            ST_PARITY: tx_next = par_bit;
            default:   tx_next = 1'b1;
        endcase

        busy_next = (state != ST_IDLE) | (o_fifo_cnt != '0);
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three instances with different parameter sets, each
// checked cycle by cycle against a line-level frame model built from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx_param;

    localparam int CPB      = 4;
    localparam int CPB_SLOW = 5208;

    typedef bit bit_q_t[$];

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_valid, b_valid, c_valid;
    logic [7:0] a_data, c_data;
    logic [6:0] b_data;
    logic       a_ready, b_ready, c_ready;
    logic       a_tx, b_tx, c_tx;
    logic       a_busy, b_busy, c_busy;
    logic [2:0] a_cnt, b_cnt, c_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clock(clock), .i_reset_n(reset_n), .i_valid(a_valid), .i_data(a_data),
        .o_ready(a_ready), .o_tx(a_tx), .o_busy(a_busy), .o_fifo_cnt(a_cnt));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clock(clock), .i_reset_n(reset_n), .i_valid(b_valid), .i_data(b_data),
        .o_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_fifo_cnt(b_cnt));

    uart_tx_param #(.CLKS_PER_BIT(CPB_SLOW), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clock(clock), .i_reset_n(reset_n), .i_valid(c_valid), .i_data(c_data),
        .o_ready(c_ready), .o_tx(c_tx), .o_busy(c_busy), .o_fifo_cnt(c_cnt));

    // Line level for every clock of one frame: start, data LSB first, optional parity, stop bits
    function automatic bit_q_t frame_bits(input int word, input int nbits, input int pmode,
                                          input int nstop, input int cpb);
        bit_q_t q;
        int     ones;
        bit     b;
        ones = 0;
        for (int k = 0; k < cpb; k++) q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            b = bit'((word >> i) & 1);
            ones += int'(b);
            for (int k = 0; k < cpb; k++) q.push_back(b);
        end
        if (pmode != 0) begin
            b = (pmode == 1) ? bit'(ones % 2) : bit'(1 - (ones % 2));
            for (int k = 0; k < cpb; k++) q.push_back(b);
        end
        for (int k = 0; k < nstop * cpb; k++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data  = '0;   b_data  = '0;   c_data  = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (a_tx !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_cnt !== 3'd0)
            $display("[TB] FAIL reset_a: tx=%b ready=%b busy=%b cnt=%0d, expected 1 1 0 0", a_tx, a_ready, a_busy, a_cnt);
        checks++;
        if (b_tx !== 1'b1 || b_ready !== 1'b1 || b_busy !== 1'b0 || b_cnt !== 3'd0)
            $display("[TB] FAIL reset_b: tx=%b ready=%b busy=%b cnt=%0d, expected 1 1 0 0", b_tx, b_ready, b_busy, b_cnt);
        checks++;
        if (c_tx !== 1'b1 || c_ready !== 1'b1 || c_busy !== 1'b0 || c_cnt !== 3'd0)
            $display("[TB] FAIL reset_c: tx=%b ready=%b busy=%b cnt=%0d, expected 1 1 0 0", c_tx, c_ready, c_busy, c_cnt);
        if (a_tx !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_cnt !== 3'd0 ||
            b_tx !== 1'b1 || b_busy !== 1'b0 || c_tx !== 1'b1 || c_busy !== 1'b0) errors++;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || b_tx !== 1'b1 || b_busy !== 1'b0 || c_tx !== 1'b1 || c_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_quiet cycle %0d: tx a/b/c=%b%b%b busy a/b/c=%b%b%b, expected tx 111 busy 000",
                         i, a_tx, b_tx, c_tx, a_busy, b_busy, c_busy);
            end
        end
    endtask

    task automatic test_8n1(input logic [7:0] data);
        bit_q_t exp;
        exp = frame_bits(int'(data), 8, 0, 1, CPB);
        a_data  = data;
        a_valid = 1'b1;
        @(negedge clock);
        a_valid = 1'b0;
        a_data  = 8'($urandom);
        checks++;
        if (a_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 8n1_latency_n data=%h: o_tx=%b expected 1", data, a_tx);
        end
        @(negedge clock);
        checks++;
        if (a_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 8n1_latency_n1 data=%h: o_tx=%b expected 1", data, a_tx);
        end
        foreach (exp[i]) begin
            @(negedge clock);
            checks++;
            if (a_tx !== exp[i]) begin
                errors++;
                $display("[TB] FAIL 8n1_line data=%h cycle %0d: o_tx=%b expected %b", data, i, a_tx, exp[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (a_busy !== 1'b0 || a_tx !== 1'b1 || a_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL 8n1_idle_after data=%h: busy=%b tx=%b cnt=%0d, expected 0 1 0", data, a_busy, a_tx, a_cnt);
        end
    endtask

    task automatic test_parity_7o2(input logic [6:0] data);
        bit_q_t exp;
        exp = frame_bits(int'(data), 7, 2, 2, CPB);
        b_data  = data;
        b_valid = 1'b1;
        @(negedge clock);
        b_valid = 1'b0;
        b_data  = 7'($urandom);
        @(negedge clock);
        checks++;
        if (b_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 7o2_latency data=%h: o_tx=%b expected 1", data, b_tx);
        end
        foreach (exp[i]) begin
            @(negedge clock);
            checks++;
            if (b_tx !== exp[i]) begin
                errors++;
                $display("[TB] FAIL 7o2_line data=%h cycle %0d: o_tx=%b expected %b", data, i, b_tx, exp[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 7o2_idle_after data=%h: busy=%b tx=%b, expected 0 1", data, b_busy, b_tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        bit_q_t     exp;
        bit_q_t     one;
        int         n;
        foreach (words[k]) begin
            words[k] = 8'($urandom);
            one = frame_bits(int'(words[k]), 8, 0, 1, CPB);
            foreach (one[j]) exp.push_back(one[j]);
        end
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    a_valid = 1'b1;
                    a_data  = words[k];
                    n = 0;
                    while (a_ready !== 1'b1 && n < 200) begin
                        @(negedge clock);
                        n++;
                    end
                    if (k == 5) begin
                        checks++;
                        if (n != 37) begin
                            errors++;
                            $display("[TB] FAIL b2b_stall_len: waited %0d cycles for o_ready, expected 37", n);
                        end
                    end
                    @(negedge clock);
                    if (k == 4) begin
                        checks++;
                        if (a_cnt !== 3'd4 || a_ready !== 1'b0) begin
                            errors++;
                            $display("[TB] FAIL b2b_full: cnt=%0d ready=%b, expected 4 0", a_cnt, a_ready);
                        end
                    end
                end
                a_valid = 1'b0;
            end
            begin
                @(negedge clock);
                @(negedge clock);
                foreach (exp[i]) begin
                    @(negedge clock);
                    checks++;
                    if (a_tx !== exp[i]) begin
                        errors++;
                        $display("[TB] FAIL b2b_line frame %0d cycle %0d: o_tx=%b expected %b", i / 40, i % 40, a_tx, exp[i]);
                    end
                end
            end
        join
        @(negedge clock);
        checks++;
        if (a_busy !== 1'b0 || a_cnt !== 3'd0 || a_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_idle_after: busy=%b cnt=%0d tx=%b, expected 0 0 1", a_busy, a_cnt, a_tx);
        end
    endtask

    task automatic test_reset_mid_frame();
        a_data  = 8'($urandom);
        a_valid = 1'b1;
        @(negedge clock);
        a_data = 8'($urandom);
        @(negedge clock);
        a_valid = 1'b0;
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_tx !== 1'b1 || a_cnt !== 3'd0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_reset: tx=%b cnt=%0d busy=%b ready=%b, expected 1 0 0 1", a_tx, a_cnt, a_busy, a_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midframe_flushed cycle %0d: tx=%b busy=%b, expected 1 0", i, a_tx, a_busy);
            end
        end
        test_8n1(8'($urandom));
    endtask

    task automatic test_slow_baud();
        int low;
        int hi_bad;
        c_data  = 8'h00;
        c_valid = 1'b1;
        @(negedge clock);
        c_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (c_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slow_latency: o_tx=%b expected 1", c_tx);
        end
        low = 0;
        while (low < 60000) begin
            @(negedge clock);
            if (c_tx !== 1'b0) break;
            low++;
        end
        checks++;
        if (low != 9 * CPB_SLOW) begin
            errors++;
            $display("[TB] FAIL slow_low_len: low for %0d cycles, expected %0d", low, 9 * CPB_SLOW);
        end
        hi_bad = (c_tx !== 1'b1) ? 1 : 0;
        for (int i = 1; i < CPB_SLOW; i++) begin
            @(negedge clock);
            if (c_tx !== 1'b1) hi_bad++;
        end
        checks++;
        if (hi_bad != 0) begin
            errors++;
            $display("[TB] FAIL slow_stop: %0d low cycles in stop bit, expected 0", hi_bad);
        end
        @(negedge clock);
        checks++;
        if (c_busy !== 1'b0 || c_tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slow_idle_after: busy=%b tx=%b, expected 0 1", c_busy, c_tx);
        end
    endtask

    initial begin
        test_reset();
        test_8n1(8'hA5);
        test_8n1(8'($urandom));
        test_8n1(8'($urandom));
        test_parity_7o2(7'h55);
        test_parity_7o2(7'($urandom));
        test_parity_7o2(7'($urandom));
        test_back_to_back();
        test_reset_mid_frame();
        test_slow_baud();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected the test sequence to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
